// File: rtl/vocab_decoder.sv
// Vocabulary decoder: walks null-terminated words in SRAM to word number `id` and streams its bytes (null last).
// Optional VOCAB_DECODER_LEN_EN adds word_len, the count of non-null beats handshaken for the current word.
module vocab_decoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int END_ADDR   = 2**ADDR_WIDTH-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic [ID_WIDTH-1:0]   id,
  output logic                  mem_cs,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  found
`ifdef VOCAB_DECODER_LEN_EN
  ,output logic [ADDR_WIDTH-1:0] word_len
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(END_ADDR);

  typedef enum logic [1:0] {IDLE, SKIP, STREAM, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ID_WIDTH-1:0]   remaining;
  logic                  pend;       // a read is in flight; mem_rdata belongs to addr this cycle
  logic                  wstart;     // the pending SKIP read sits at a word-start position
  logic                  have_char;
  logic                  start, hs, at_end, rd_null;

  assign start    = cs && (state == IDLE || state == DONE);
  assign hs       = out_valid && out_ready;
  assign at_end   = (addr == LAST_ADDR);
  assign rd_null  = (mem_rdata == '0);
  assign mem_addr = addr;
  assign busy     = (state == SKIP) || (state == STREAM);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_cs    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (cs) state_nxt = (id == '0) ? STREAM : SKIP;
      end
      SKIP: begin
        mem_cs = !pend;
        if (pend) begin
          if (at_end || (rd_null && wstart))             state_nxt = DONE;
          else if (rd_null && remaining == ID_WIDTH'(1)) state_nxt = STREAM;
        end
      end
      STREAM: begin
        // Only refill when the output register is empty or about to drain a non-final beat.
        mem_cs = !pend && (!out_valid || (out_ready && !out_last));
        if (pend && rd_null && !have_char) state_nxt = DONE;
        if (hs && out_last)                state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      pend      <= 1'b0;
      wstart    <= 1'b0;
      have_char <= 1'b0;
      found     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (start) begin
      addr      <= '0;
      remaining <= id;
      pend      <= 1'b0;
      wstart    <= 1'b1;
      have_char <= 1'b0;
      found     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (mem_cs) pend <= 1'b1;
      case (state)
        SKIP: begin
          if (pend) begin
            pend   <= 1'b0;
            wstart <= rd_null;
            if (!at_end) addr <= addr + ADDR_WIDTH'(1);
            if (rd_null) remaining <= remaining - ID_WIDTH'(1);
          end
        end
        STREAM: begin
          if (hs) begin
            out_valid <= 1'b0;
            if (out_last) begin
              found    <= (out_data == '0);
              out_last <= 1'b0;
            end
          end
          // The register is always empty when read data returns, so loading never collides with a held beat.
          if (pend) begin
            pend <= 1'b0;
            if (!rd_null || have_char) begin
              out_data  <= mem_rdata;
              out_valid <= 1'b1;
              out_last  <= rd_null || at_end;
              have_char <= 1'b1;
              if (!at_end) addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VOCAB_DECODER_LEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      word_len <= '0;
    else if (start)                  word_len <= '0;
    else if (hs && out_data != '0)   word_len <= word_len + ADDR_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_vocab_decoder.sv
// Self-checking bench for vocab_decoder: table of decode cases plus hand-written reset and busy-cs sequences.
module tb_vocab_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic [3:0] id;
  logic       mem_cs;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       found;
`ifdef VOCAB_DECODER_LEN_EN
  logic [3:0] word_len;
`endif

  vocab_decoder dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .id(id),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .found(found)
`ifdef VOCAB_DECODER_LEN_EN
    , .word_len(word_len)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] vocab [16];
  always @(posedge clk) if (mem_cs) mem_rdata <= vocab[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard of expected beats {last, data}
  logic [8:0] q [$];
  int   nbeats;
  int   first_cyc;
  int   rdy_mode = 0;
  logic stall_prev = 1'b0;
  logic [8:0] stall_beat;

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (stall_prev) chk("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, stall_beat});
    if (out_valid && first_cyc < 0) first_cyc = cyc;
    if (out_valid && out_ready) begin
      nbeats++;
      if (q.size() == 0) chk("extra_beat", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
      else chk("beat", {23'd0, out_last, out_data}, {23'd0, q.pop_front()});
    end
    stall_prev = out_valid && !out_ready;
    stall_beat = {out_last, out_data};
  end

  task automatic load_vocab(input int sel);
    logic [7:0] s [9];
    s = '{8'h63, 8'h61, 8'h74, 8'h00, 8'h64, 8'h6f, 8'h67, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) vocab[i] = (sel == 1) ? 8'(8'h41 + i) : ((i < 9) ? s[i] : 8'h00);
  endtask

  // Independent walk of the vocab to produce the expected beat sequence for a given id.
  task automatic model(input logic [3:0] tid);
    int a;
    a = 0;
    for (int w = 0; w < int'(tid); w++) begin
      if (vocab[a] == 8'h00) return;
      while (vocab[a] != 8'h00) begin
        if (a == 15) return;
        a++;
      end
      if (a == 15) return;
      a++;
    end
    if (vocab[a] == 8'h00) return;
    forever begin
      q.push_back({(vocab[a] == 8'h00) || (a == 15), vocab[a]});
      if (vocab[a] == 8'h00 || a == 15) break;
      a++;
    end
  endtask

  typedef struct {
    int         sel;
    logic [3:0] tid;
    int         mode;
    int         beats;
    logic       fnd;
    int         max_lat;
  } vec_t;

  vec_t tv [8];

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_case(input vec_t v);
    int k;
    load_vocab(v.sel);
    rdy_mode = v.mode;
    model(v.tid);
    nbeats = 0;
    first_cyc = -1;
    @(posedge clk);
    #1;
    cs = 1'b1;
    id = v.tid;
    k  = cyc;
    @(posedge clk);
    #1;
    cs = 1'b0;
    id = 4'hF;
    chk("busy_on_accept", {30'd0, busy, done}, 32'd2);
    wait_done("case");
    chk("found", {31'd0, found}, {31'd0, v.fnd});
    chk("beat_count", nbeats, v.beats);
    chk("queue_drained", q.size(), 0);
    if (v.beats > 0) chk("latency_ok", {31'd0, (first_cyc - k) <= v.max_lat}, 32'd1);
`ifdef VOCAB_DECODER_LEN_EN
    chk("word_len", {28'd0, word_len}, v.beats - int'(v.fnd));
`endif
  endtask

  initial begin
    vec_t v;
    int t;
    rst_n = 1'b0;
    cs    = 1'b0;
    id    = 4'd0;
    out_ready = 1'b1;
    load_vocab(0);
    #1;
    chk("reset_outputs", {out_data, mem_addr, mem_cs, out_valid, out_last, busy, done, found},
        {8'h00, 4'h0, 6'b000000});
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    tv[0] = '{0, 4'd1, 0, 4,  1'b1, 11};
    tv[1] = '{0, 4'd0, 0, 4,  1'b1, 3};
    tv[2] = '{0, 4'd2, 0, 0,  1'b0, 0};
    tv[3] = '{0, 4'd1, 1, 4,  1'b1, 11};
    tv[4] = '{1, 4'd0, 0, 16, 1'b0, 3};
    tv[5] = '{1, 4'd1, 0, 0,  1'b0, 0};
    tv[6] = '{0, 4'd0, 2, 4,  1'b1, 3};
    tv[7] = '{0, 4'd3, 0, 0,  1'b0, 0};
    for (int i = 0; i < 8; i++) begin
      run_case(tv[i]);
      chk("done_level", {31'd0, done}, 32'd1);
    end

    // Reset mid-stream after the first beat of "dog"
    load_vocab(0);
    rdy_mode = 0;
    model(4'd1);
    nbeats = 0;
    @(posedge clk);
    #1 cs = 1'b1; id = 4'd1;
    @(posedge clk);
    #1 cs = 1'b0;
    t = 0;
    while (nbeats < 1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("first_beat_seen", nbeats, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {out_data, mem_addr, mem_cs, out_valid, out_last, busy, done, found},
        {8'h00, 4'h0, 6'b000000});
    q.delete();
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("no_beats_after_reset", nbeats, 1);
    v = '{0, 4'd0, 0, 4, 1'b1, 3};
    run_case(v);

    // cs with id=0 while busy on id=1 must be ignored
    model(4'd1);
    nbeats = 0;
    @(posedge clk);
    #1 cs = 1'b1; id = 4'd1;
    @(posedge clk);
    #1 cs = 1'b1; id = 4'd0;
    chk("busy_when_recs", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 cs = 1'b0;
    wait_done("busy_cs");
    chk("busy_cs_found", {31'd0, found}, 32'd1);
    chk("busy_cs_beats", nbeats, 4);
    chk("busy_cs_queue", q.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
